// File: rtl/nmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nmi_arbiter
// Purpose  : Round-robin arbiter merging NUM_MST native-memory-interface
//            initiators onto a single NMI target port. The grant is held for
//            the whole transaction. A bus watchdog completes a stalled
//            transaction with ERR_DATA so that no initiator can hang.
// Ports    : clk_i, rst_i         - clock, synchronous active-high reset
//            mst_valid_i          - per-initiator request valid
//            mst_addr_i/wdata_i   - per-initiator 32-bit fields, packed k*32
//            mst_wstrb_i          - per-initiator byte strobes (0 = read)
//            mst_ready_o          - per-initiator completion pulse
//            mst_rdata_o          - shared read data, qualified by ready
//            slv_*                - target request / response port
//            grant_o              - one-hot current owner (0 when idle)
//            timeout_o            - pulse on watchdog completion
// Revision : 1.0 - initial release
// ============================================================================
module nmi_arbiter #(
  parameter int          NUM_MST  = 2,
  parameter int          TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_MST-1:0]   mst_valid_i,
  input  logic [NUM_MST*32-1:0] mst_addr_i,
  input  logic [NUM_MST*32-1:0] mst_wdata_i,
  input  logic [NUM_MST*4-1:0] mst_wstrb_i,
  output logic [NUM_MST-1:0]   mst_ready_o,
  output logic [31:0]          mst_rdata_o,
  output logic                 slv_valid_o,
  output logic [31:0]          slv_addr_o,
  output logic [31:0]          slv_wdata_o,
  output logic [3:0]           slv_wstrb_o,
  input  logic [31:0]          slv_rdata_i,
  input  logic                 slv_ready_i,
  output logic [NUM_MST-1:0]   grant_o,
  output logic                 timeout_o
);

  localparam int IDXW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  // A disabled watchdog still keeps a 1-bit counter so no zero-width vector exists.
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   c_TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0]   c_CNT_MAX = '1;
  localparam logic [IDXW-1:0] c_LAST_RST = IDXW'(NUM_MST - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_grant, w_grant_nxt;
  logic [IDXW-1:0] r_last,  w_last_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;

  logic [IDXW-1:0]    w_arb_sel;
  logic [IDXW-1:0]    w_hi_sel, w_lo_sel;
  logic               w_hi_found, w_lo_found;
  logic               w_sel_valid;
  logic [31:0]        w_sel_addr, w_sel_wdata;
  logic [3:0]         w_sel_wstrb;
  logic [NUM_MST-1:0] w_gnt_onehot;
  logic               w_timeout;

  // Round-robin pick: the lowest requester above the last owner wins; if none
  // exists, the scan wraps and the lowest requester overall wins.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_found = 1'b0;
    w_lo_sel   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (mst_valid_i[k]) begin
        if (!w_hi_found && (IDXW'(k) > r_last)) begin
          w_hi_found = 1'b1;
          w_hi_sel   = IDXW'(k);
        end
        if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_sel   = IDXW'(k);
        end
      end
    end
    w_arb_sel = w_hi_found ? w_hi_sel : w_lo_sel;
  end

  // Field multiplexer for the registered owner.
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_addr   = '0;
    w_sel_wdata  = '0;
    w_sel_wstrb  = '0;
    w_gnt_onehot = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (r_grant == IDXW'(k)) begin
        w_sel_valid     = mst_valid_i[k];
        w_sel_addr      = mst_addr_i[32*k +: 32];
        w_sel_wdata     = mst_wdata_i[32*k +: 32];
        w_sel_wstrb     = mst_wstrb_i[4*k +: 4];
        w_gnt_onehot[k] = 1'b1;
      end
    end
  end

  assign w_timeout = (TIMEOUT > 0) && (r_cnt == c_TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= c_LAST_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    mst_ready_o = '0;
    mst_rdata_o = '0;
    slv_valid_o = 1'b0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    grant_o     = '0;
    timeout_o   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (|mst_valid_i) begin
          w_state_nxt = S_BUSY;
          w_grant_nxt = w_arb_sel;
        end
      end

      S_BUSY: begin
        grant_o     = w_gnt_onehot;
        slv_addr_o  = w_sel_addr;
        slv_wdata_o = w_sel_wdata;
        slv_wstrb_o = w_sel_wstrb;
        // The target ready takes priority over an expiring watchdog, so the
        // request is only withdrawn when the target has not answered.
        slv_valid_o = w_sel_valid & ~(w_timeout & ~slv_ready_i);
        w_cnt_nxt   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

        if (!w_sel_valid) begin
          // Owner abandoned its request: release the bus without a ready.
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_grant;
          w_cnt_nxt   = '0;
        end else if (slv_ready_i) begin
          mst_ready_o = w_gnt_onehot;
          mst_rdata_o = slv_rdata_i;
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_grant;
          w_cnt_nxt   = '0;
        end else if (w_timeout) begin
          mst_ready_o = w_gnt_onehot;
          mst_rdata_o = ERR_DATA;
          timeout_o   = 1'b1;
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_grant;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmi_arbiter
// Purpose  : Self-checking bench for nmi_arbiter (2 initiators, TIMEOUT=8).
//            Stimulus queues expected responses; a monitor pops and compares
//            on every initiator ready and every accepted target request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nmi_arbiter;

  localparam int          NM  = 2;
  localparam logic [31:0] BAD = 32'hBAD0_0000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NM-1:0]    mst_valid_i;
  logic [NM*32-1:0] mst_addr_i, mst_wdata_i;
  logic [NM*4-1:0]  mst_wstrb_i;
  logic [NM-1:0]    mst_ready_o;
  logic [31:0]      mst_rdata_o;
  logic             slv_valid_o;
  logic [31:0]      slv_addr_o, slv_wdata_o;
  logic [3:0]       slv_wstrb_o;
  logic [31:0]      slv_rdata_i;
  logic             slv_ready_i;
  logic [NM-1:0]    grant_o;
  logic             timeout_o;

  nmi_arbiter #(.NUM_MST(NM), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mst_valid_i(mst_valid_i), .mst_addr_i(mst_addr_i), .mst_wdata_i(mst_wdata_i),
    .mst_wstrb_i(mst_wstrb_i), .mst_ready_o(mst_ready_o), .mst_rdata_o(mst_rdata_o),
    .slv_valid_o(slv_valid_o), .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
    .slv_wstrb_o(slv_wstrb_o), .slv_rdata_i(slv_rdata_i), .slv_ready_i(slv_ready_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { logic [31:0] rdata; logic to; int lat; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int m; } slv_t;

  req_t mq[NM][$];
  rsp_t exp_rsp[NM][$];
  slv_t exp_slv[$];
  int   exp_gnt[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          tgt_lat = 1;
  logic [31:0] tgt_rdata = '0;
  logic        done_m[NM];
  int          issue_cyc[NM];
  logic        after_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] rd, input logic to,
                       input int lat);
    req_t r;
    rsp_t e;
    slv_t s;
    r.addr = a; r.wdata = wd; r.wstrb = ws;
    e.rdata = rd; e.to = to; e.lat = lat;
    s.addr = a; s.wdata = wd; s.wstrb = ws; s.m = m;
    mq[m].push_back(r);
    exp_rsp[m].push_back(e);
    exp_gnt.push_back(m);
    if (!to) exp_slv.push_back(s);
  endtask

  task automatic enter_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_gnt.size() != 0 || exp_slv.size() != 0) && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (exp_gnt.size() != 0 || exp_slv.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: %0d responses still outstanding, required 0", exp_gnt.size());
      exp_gnt.delete();
      exp_slv.delete();
      for (int m = 0; m < NM; m++) exp_rsp[m].delete();
    end
    repeat (3) @(negedge clk_i);
  endtask

  // Cycle counter shared by driver and monitor for latency measurement.
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Initiator drivers: hold a request until its ready, then load the next.
  initial begin
    mst_valid_i = '0; mst_addr_i = '0; mst_wdata_i = '0; mst_wstrb_i = '0;
    for (int m = 0; m < NM; m++) begin done_m[m] = 1'b0; issue_cyc[m] = 0; end
    forever begin
      @(posedge clk_i);
      #1;
      for (int m = 0; m < NM; m++) begin
        if (rst_i) begin
          mst_valid_i[m] = 1'b0;
          done_m[m]      = 1'b0;
        end else if (done_m[m] || !mst_valid_i[m]) begin
          done_m[m] = 1'b0;
          if (mq[m].size() > 0) begin
            req_t r;
            r = mq[m].pop_front();
            mst_addr_i[32*m +: 32]  = r.addr;
            mst_wdata_i[32*m +: 32] = r.wdata;
            mst_wstrb_i[4*m +: 4]   = r.wstrb;
            mst_valid_i[m]          = 1'b1;
            issue_cyc[m]            = cyc;
          end else begin
            mst_valid_i[m] = 1'b0;
          end
        end
      end
    end
  end

  // Target model: ready on BUSY cycle tgt_lat+1; address BAD never answers.
  initial begin
    int vc;
    vc = 0;
    slv_ready_i = 1'b0;
    slv_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!rst_i && (grant_o != '0)) begin
        if (slv_addr_o != BAD && vc == tgt_lat) begin
          slv_ready_i = 1'b1;
          slv_rdata_i = tgt_rdata;
        end else begin
          slv_ready_i = 1'b0;
          slv_rdata_i = '0;
        end
        vc++;
      end else begin
        slv_ready_i = 1'b0;
        slv_rdata_i = '0;
        vc = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk_i);
    if (after_done) begin
      check("idle_gap_grant", 32'(grant_o), 32'd0);
      after_done = 1'b0;
    end
    if (|mst_ready_o) begin
      int   m;
      rsp_t e;
      m = mst_ready_o[1] ? 1 : 0;
      check("ready_onehot", 32'($countones(mst_ready_o)), 32'd1);
      if (exp_gnt.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_ready: got initiator %0d, required none", m);
      end else begin
        check("grant_order", 32'(m), 32'(exp_gnt.pop_front()));
      end
      if (exp_rsp[m].size() != 0) begin
        e = exp_rsp[m].pop_front();
        check("rdata", mst_rdata_o, e.rdata);
        check("timeout_flag", 32'(timeout_o), 32'(e.to));
        check("latency", 32'(cyc - issue_cyc[m]), 32'(e.lat));
        if (e.to) check("slv_valid_on_timeout", 32'(slv_valid_o), 32'd0);
      end
      done_m[m]  = 1'b1;
      after_done = 1'b1;
    end else if (timeout_o) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_without_ready: got 1 required 0");
    end
    if (slv_valid_o && slv_ready_i) begin
      if (exp_slv.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_slv_access: got addr %h, required none", slv_addr_o);
      end else begin
        slv_t s;
        s = exp_slv.pop_front();
        check("slv_addr", slv_addr_o, s.addr);
        check("slv_wdata", slv_wdata_o, s.wdata);
        check("slv_wstrb", 32'(slv_wstrb_o), 32'(s.wstrb));
        check("slv_grant", 32'(grant_o), 32'(1 << s.m));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_mst_ready", 32'(mst_ready_o), 32'd0);
    check("rst_mst_rdata", mst_rdata_o, 32'd0);
    check("rst_slv_valid", 32'(slv_valid_o), 32'd0);
    check("rst_slv_addr", slv_addr_o, 32'd0);
    check("rst_slv_wdata", slv_wdata_o, 32'd0);
    check("rst_slv_wstrb", 32'(slv_wstrb_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);

    // Single read, target answers two cycles after the request appears.
    tgt_lat = 2; tgt_rdata = 32'h1234_5678;
    issue(0, 32'h1000_1004, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3);
    rst_i = 1'b0;
    wait_done();

    // Contention: 0, then 1, then 0 again.
    enter_reset();
    tgt_lat = 1; tgt_rdata = 32'hCAFE_0001;
    issue(0, 32'h2000_0000, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 2);
    issue(1, 32'h2000_0100, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 5);
    issue(0, 32'h2000_0004, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 5);
    rst_i = 1'b0;
    wait_done();

    // Back-to-back writes from initiator 1.
    enter_reset();
    tgt_lat = 1; tgt_rdata = 32'h0;
    issue(1, 32'h4000_0010, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 2);
    issue(1, 32'h4000_0014, 32'hA5A5_0002, 4'h3, 32'h0, 1'b0, 2);
    rst_i = 1'b0;
    wait_done();

    // Watchdog: initiator 0 stalls, initiator 1 is served afterwards.
    enter_reset();
    tgt_lat = 1; tgt_rdata = 32'h5555_AAAA;
    issue(0, BAD, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, 8);
    issue(1, 32'h2000_0200, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0, 11);
    rst_i = 1'b0;
    wait_done();

    // Ready arrives on the same cycle the watchdog would fire.
    enter_reset();
    tgt_lat = 7; tgt_rdata = 32'h0000_00FF;
    issue(0, 32'h3000_0000, 32'h0, 4'h0, 32'h0000_00FF, 1'b0, 8);
    rst_i = 1'b0;
    wait_done();

    // Reset in the middle of a transaction.
    enter_reset();
    tgt_lat = 1; tgt_rdata = 32'h7777_0000;
    begin
      req_t r;
      r.addr = BAD; r.wdata = '0; r.wstrb = '0;
      mq[0].push_back(r);
    end
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("mid_busy_grant", 32'(grant_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_grant", 32'(grant_o), 32'd0);
    check("mid_rst_slv_valid", 32'(slv_valid_o), 32'd0);
    check("mid_rst_slv_addr", slv_addr_o, 32'd0);
    check("mid_rst_mst_ready", 32'(mst_ready_o), 32'd0);
    issue(0, 32'h5000_0000, 32'h0, 4'h0, 32'h7777_0000, 1'b0, 2);
    issue(1, 32'h5000_0100, 32'h0, 4'h0, 32'h7777_0000, 1'b0, 5);
    rst_i = 1'b0;
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
